gpio_in_debouncer: RTL and testbench

- Conditions the raw 8-bit board switch/button inputs before they reach the processor's GPIO input port.
- Each bit is passed through a 2-flop synchronizer and a per-bit stability counter.
- The processor only ever sees clean, metastability-free levels.
- Single-cycle rise/fall/change pulses are also produced, for use by future interrupt or edge-capture logic.

---
 rtl/gpio_in_debouncer.sv | 91 +++++++++
 tb/tb_gpio_in_debouncer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debouncer.sv
// gpio_in_debouncer: conditions raw asynchronous switch/button pins for the
// processor GPIO input port. Each bit goes through a two-flop synchronizer.
// A per-bit stability counter then lets the debounced level follow only after
// the synchronized input has disagreed with it for STABLE_CYCLES consecutive
// cycles. Registered rise/fall/change pulses mark every debounced transition.
module gpio_in_debouncer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    STABLE_CYCLES = 500000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gpio_i,
  output logic [DATA_WIDTH-1:0] gpio_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o,
  output logic                  change_o
);

  // A counter wide enough to hold STABLE_CYCLES. It never reaches that value,
  // because it clears on the cycle it would otherwise hit STABLE_CYCLES.
  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [CNT_W-1:0]      cnt      [DATA_WIDTH];
  logic [CNT_W-1:0]      cnt_next [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] level_next;
  logic [DATA_WIDTH-1:0] rise_next;
  logic [DATA_WIDTH-1:0] fall_next;

  // Two-flop synchronizer; only sync2 is allowed to feed the debounce logic.
  always_ff @(posedge clk) begin
    // NOTE: state is always assigned with <= so every flop samples the values
    // that existed before this edge, independent of statement order.
    if (reset) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision: count disagreeing cycles, follow on the last one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    level_next = gpio_o;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != gpio_o[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = sync2[i];
          rise_next[i]  = sync2[i];
          fall_next[i]  = ~sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced level, counters and edge pulses; reset discards any count progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is reset explicitly, because a partial count
      // must never survive reset and shorten the next debounce interval.
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt[i] <= '0;
      end
      gpio_o   <= RESET_VALUE;
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
      gpio_o   <= level_next;
      rise_o   <= rise_next;
      fall_o   <= fall_next;
      change_o <= |(rise_next | fall_next);
    end
  end

endmodule

// File: tb/tb_gpio_in_debouncer.sv
// Testbench for gpio_in_debouncer with STABLE_CYCLES=4 and RESET_VALUE=0.
// It runs table-driven scenario vectors, a hand-written bounded wait on a
// multi-bit fall, and randomized bursts. The randomized bursts are compared
// against a history-window reference model.
module tb_gpio_in_debouncer;

  localparam int S = 4;

  logic       clk;
  logic       reset;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       change_o;

  int checks;
  int errors;

  gpio_in_debouncer #(
    .DATA_WIDTH   (8),
    .STABLE_CYCLES(S),
    .RESET_VALUE  (8'h00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .change_o(change_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. A debounced bit flips at an edge when the last S
  // synchronized samples seen since reset all disagree with it.
  logic [7:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic       m_chg;
  logic [7:0] hist[$];

  always @(posedge clk) begin
    logic [7:0] nxt;
    logic       all_diff;
    if (reset) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_out = 8'h00;
      m_rise = 8'h00; m_fall = 8'h00; m_chg = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > S) void'(hist.pop_front());
      nxt = m_out;
      for (int b = 0; b < 8; b++) begin
        if (hist.size() == S) begin
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_out[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = ~m_out[b];
        end
      end
      m_rise = nxt & ~m_out;
      m_fall = ~nxt & m_out;
      m_chg  = |(m_rise | m_fall);
      m_out  = nxt;
      m_s2   = m_s1;
      m_s1   = gpio_i;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cycle(input logic r, input logic [7:0] d);
    reset  = r;
    gpio_i = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic [7:0] exp_o;
    logic [7:0] exp_rise;
    logic [7:0] exp_fall;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] d, input logic [7:0] o,
                     input logic [7:0] ri, input logic [7:0] fa, input logic ch);
    vec_t v;
    v.rst = r; v.din = d; v.exp_o = o; v.exp_rise = ri; v.exp_fall = fa; v.exp_chg = ch;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    gpio_i = 8'hFF;

    // Reset held three edges with all pins high, then release.
    for (int i = 0; i < 3; i++) add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // Bit 0 rises: new level visible after the sixth edge (k+5), one-cycle pulse.
    for (int i = 0; i < 5; i++) add(0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    // Bit 2 glitch of three cycles is rejected.
    for (int i = 0; i < 3; i++) add(0, 8'h05, 8'h01, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    // Bit 2 held: updates normally.
    for (int i = 0; i < 5; i++) add(0, 8'h05, 8'h01, 8'h00, 8'h00, 0);
    add(0, 8'h05, 8'h05, 8'h04, 8'h00, 1);
    add(0, 8'h05, 8'h05, 8'h00, 8'h00, 0);
    // Move to 0x80, then simultaneous rise of bit 0 and fall of bit 7.
    for (int i = 0; i < 5; i++) add(0, 8'h80, 8'h05, 8'h00, 8'h00, 0);
    add(0, 8'h80, 8'h80, 8'h80, 8'h05, 1);
    add(0, 8'h80, 8'h80, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h01, 8'h80, 8'h00, 8'h00, 0);
    add(0, 8'h01, 8'h01, 8'h01, 8'h80, 1);
    add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    // Reset mid-count: progress discarded, full count after release.
    for (int i = 0; i < 4; i++) add(0, 8'h10, 8'h01, 8'h00, 8'h00, 0);
    add(1, 8'h10, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h10, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h10, 8'h10, 8'h10, 8'h00, 1);
    add(0, 8'h10, 8'h10, 8'h00, 8'h00, 0);
    // Staggered bits: bit 0 at k, bit 1 at k+2 give two separate pulses.
    add(0, 8'h11, 8'h10, 8'h00, 8'h00, 0);
    add(0, 8'h11, 8'h10, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h13, 8'h10, 8'h00, 8'h00, 0);
    add(0, 8'h13, 8'h11, 8'h01, 8'h00, 1);
    add(0, 8'h13, 8'h11, 8'h00, 8'h00, 0);
    add(0, 8'h13, 8'h13, 8'h02, 8'h00, 1);
    add(0, 8'h13, 8'h13, 8'h00, 8'h00, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].din);
      check($sformatf("vec%0d gpio_o", i), gpio_o, vecs[i].exp_o);
      check($sformatf("vec%0d rise_o", i), rise_o, vecs[i].exp_rise);
      check($sformatf("vec%0d fall_o", i), fall_o, vecs[i].exp_fall);
      check($sformatf("vec%0d change_o", i), {7'd0, change_o}, {7'd0, vecs[i].exp_chg});
    end

    // Three bits fall together. The wait for the update is bounded, and the
    // update must land on the sixth edge with one shared change pulse.
    n = 0;
    do begin
      cycle(0, 8'h00);
      n++;
    end while (gpio_o !== 8'h00 && n < 20);
    check("multi-fall latency", 8'(n), 8'd6);
    check("multi-fall gpio_o", gpio_o, 8'h00);
    check("multi-fall fall_o", fall_o, 8'h13);
    check("multi-fall change_o", {7'd0, change_o}, 8'h01);
    cycle(0, 8'h00);
    check("multi-fall pulse end", {7'd0, change_o}, 8'h00);

    // Randomized bursts: hold a random value for a random run, with occasional reset.
    for (int burst = 0; burst < 150; burst++) begin
      logic [7:0] val;
      int         len;
      logic       r;
      val = 8'($urandom);
      if ($urandom_range(0, 3) == 0) val = gpio_i ^ (8'h01 << $urandom_range(0, 7));
      len = $urandom_range(1, 9);
      r   = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < len; c++) begin
        cycle(r && (c == 0), val);
        check($sformatf("rnd%0d gpio_o", burst), gpio_o, m_out);
        check($sformatf("rnd%0d rise_o", burst), rise_o, m_rise);
        check($sformatf("rnd%0d fall_o", burst), fall_o, m_fall);
        check($sformatf("rnd%0d change_o", burst), {7'd0, change_o}, {7'd0, m_chg});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
